// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//   Round-robin arbiter for the common data bus (CDB). Each cycle it picks at
//   most one valid execution-stage result (ALU, MULT, LB, spare), returns a
//   one-hot written pulse in the same cycle, and registers the winning
//   tag/value for broadcast to the ROB and reservation stations next cycle.
//
// Ports
//   clock, reset        : clock; synchronous active-high reset
//   flush               : branch mispredict, suppresses grant and broadcast
//   req_valid[NUM_REQ]  : per-requester result valid
//   req_tag             : packed tags, requester i at [i*TAG_W +: TAG_W]
//   req_value           : packed values, requester i at [i*DATA_W +: DATA_W]
//   req_written         : one-hot grant, combinational, same cycle
//   cdb_valid/tag/value : registered broadcast
//   cdb_src             : index of the requester behind the current broadcast
//
// Optional build macro CDB_PERF_CNT_EN adds saturating performance counters:
//   perf_grant_cnt[NUM_REQ] : grants per requester
//   perf_conflict_cnt       : cycles with two or more valid requesters
// ---------------------------------------------------------------------------
module cdb_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned TAG_W   = 5,
   parameter int unsigned DATA_W  = 32
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        flush,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
   input  logic [NUM_REQ*DATA_W-1:0]   req_value,
   output logic [NUM_REQ-1:0]          req_written,
   output logic                        cdb_valid,
   output logic [TAG_W-1:0]            cdb_tag,
   output logic [DATA_W-1:0]           cdb_value,
`ifdef CDB_PERF_CNT_EN
   output logic [$clog2(NUM_REQ)-1:0]  cdb_src,
   output logic [31:0]                 perf_grant_cnt [NUM_REQ],
   output logic [31:0]                 perf_conflict_cnt
`else
   output logic [$clog2(NUM_REQ)-1:0]  cdb_src
`endif
);

   localparam int unsigned PTR_W = $clog2(NUM_REQ);

   logic [PTR_W-1:0]  rr_ptr;
   logic [PTR_W-1:0]  rr_ptr_next;
   logic [PTR_W-1:0]  win_idx;
   logic              win_found;
   logic              grant_en;
   int unsigned       scan_idx;

   logic [TAG_W-1:0]  tag_arr   [NUM_REQ];
   logic [DATA_W-1:0] value_arr [NUM_REQ];

   // Unpack the flat request buses into per-requester arrays.
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign tag_arr[i]   = req_tag[i*TAG_W +: TAG_W];
      assign value_arr[i] = req_value[i*DATA_W +: DATA_W];
   end

   // Pointer and broadcast register.
   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr    <= '0;
         cdb_valid <= 1'b0;
         cdb_tag   <= '0;
         cdb_value <= '0;
         cdb_src   <= '0;
      end else begin
         rr_ptr    <= rr_ptr_next;
         cdb_valid <= grant_en;
         if (grant_en) begin
            cdb_tag   <= tag_arr[win_idx];
            cdb_value <= value_arr[win_idx];
            cdb_src   <= win_idx;
         end
      end
   end

   // Rotating scan from rr_ptr; the modulo wrap is done by subtraction so a
   // non-power-of-2 NUM_REQ never indexes past the last requester.
   always_comb begin
      win_found   = 1'b0;
      win_idx     = '0;
      scan_idx    = 0;
      req_written = '0;
      rr_ptr_next = rr_ptr;

      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         scan_idx = 32'(rr_ptr) + k;
         if (scan_idx >= NUM_REQ) begin
            scan_idx = scan_idx - NUM_REQ;
         end
         if (!win_found && req_valid[PTR_W'(scan_idx)]) begin
            win_found = 1'b1;
            win_idx   = PTR_W'(scan_idx);
         end
      end

      // Reset and flush both withhold the grant; pointer then holds.
      grant_en = win_found && !reset && !flush;

      if (grant_en) begin
         req_written[win_idx] = 1'b1;
         if (win_idx == PTR_W'(NUM_REQ - 1)) begin
            rr_ptr_next = '0;
         end else begin
            rr_ptr_next = win_idx + PTR_W'(1);
         end
      end
   end

`ifdef CDB_PERF_CNT_EN
   logic [PTR_W:0] num_valid;

   // Population count of valid requesters for conflict detection.
   always_comb begin
      num_valid = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         num_valid = num_valid + (PTR_W+1)'(req_valid[i]);
      end
   end

   // Saturating grant and conflict counters.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            perf_grant_cnt[i] <= '0;
         end
         perf_conflict_cnt <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_written[i] && (perf_grant_cnt[i] != 32'hFFFF_FFFF)) begin
               perf_grant_cnt[i] <= perf_grant_cnt[i] + 32'd1;
            end
         end
         if (!flush && (num_valid >= (PTR_W+1)'(2)) &&
             (perf_conflict_cnt != 32'hFFFF_FFFF)) begin
            perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
//   Self-checking bench for cdb_arbiter: directed scenarios with literal
//   expectations, then randomized request traffic checked every cycle against
//   a behavioural model (rotating priority, one-cycle broadcast, flush/reset).
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned TAG_W   = 5;
   localparam int unsigned DATA_W  = 32;

   logic                        clock = 1'b0;
   logic                        reset;
   logic                        flush;
   logic [NUM_REQ-1:0]          req_valid;
   logic [NUM_REQ*TAG_W-1:0]    req_tag;
   logic [NUM_REQ*DATA_W-1:0]   req_value;
   logic [NUM_REQ-1:0]          req_written;
   logic                        cdb_valid;
   logic [TAG_W-1:0]            cdb_tag;
   logic [DATA_W-1:0]           cdb_value;
   logic [1:0]                  cdb_src;
`ifdef CDB_PERF_CNT_EN
   logic [31:0]                 perf_grant_cnt [NUM_REQ];
   logic [31:0]                 perf_conflict_cnt;
`endif

   logic [TAG_W-1:0]  tags [NUM_REQ];
   logic [DATA_W-1:0] vals [NUM_REQ];

   int n_checks = 0;
   int n_fail   = 0;

   cdb_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
      .clock       (clock),
      .reset       (reset),
      .flush       (flush),
      .req_valid   (req_valid),
      .req_tag     (req_tag),
      .req_value   (req_value),
      .req_written (req_written),
      .cdb_valid   (cdb_valid),
      .cdb_tag     (cdb_tag),
      .cdb_value   (cdb_value),
`ifdef CDB_PERF_CNT_EN
      .cdb_src           (cdb_src),
      .perf_grant_cnt    (perf_grant_cnt),
      .perf_conflict_cnt (perf_conflict_cnt)
`else
      .cdb_src     (cdb_src)
`endif
   );

   always #5 clock = ~clock;

   always_comb begin
      req_tag   = '0;
      req_value = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_tag[i*TAG_W +: TAG_W]    = tags[i];
         req_value[i*DATA_W +: DATA_W] = vals[i];
      end
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model + per-cycle compare ----------------
   int               m_ptr;
   bit               m_known = 1'b0;
   logic             m_valid;
   logic [TAG_W-1:0] m_tag;
   logic [DATA_W-1:0] m_value;
   int               m_src;
   int               wait_cnt [NUM_REQ];
   int               exp_idx;
   logic [NUM_REQ-1:0] exp_wr;
`ifdef CDB_PERF_CNT_EN
   longint           m_gcnt [NUM_REQ];
   longint           m_ccnt;
`endif

   always @(negedge clock) begin
      exp_idx = -1;
      if (!reset && !flush) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (exp_idx < 0 && req_valid[(m_ptr + k) % NUM_REQ])
               exp_idx = (m_ptr + k) % NUM_REQ;
         end
      end
      exp_wr = '0;
      if (exp_idx >= 0) exp_wr[exp_idx] = 1'b1;

      check("req_written", 64'(req_written), 64'(exp_wr));
      if (m_known) begin
         check("cdb_valid", 64'(cdb_valid), 64'(m_valid));
         check("cdb_tag",   64'(cdb_tag),   64'(m_tag));
         check("cdb_value", 64'(cdb_value), 64'(m_value));
         check("cdb_src",   64'(cdb_src),   64'(m_src));
         check("rr_ptr",    64'(dut.rr_ptr), 64'(m_ptr));
`ifdef CDB_PERF_CNT_EN
         for (int i = 0; i < NUM_REQ; i++)
            check("perf_grant_cnt", 64'(perf_grant_cnt[i]), 64'(m_gcnt[i]));
         check("perf_conflict_cnt", 64'(perf_conflict_cnt), 64'(m_ccnt));
`endif
      end

      if (exp_idx >= 0) check("starvation_bound", 64'(wait_cnt[exp_idx] < NUM_REQ), 64'(1));

      // advance the model to the state after the coming edge
      if (reset) begin
         m_ptr = 0; m_valid = 1'b0; m_tag = '0; m_value = '0; m_src = 0;
         m_known = 1'b1;
         for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] = 0;
`ifdef CDB_PERF_CNT_EN
         for (int i = 0; i < NUM_REQ; i++) m_gcnt[i] = 0;
         m_ccnt = 0;
`endif
      end else begin
         if (exp_idx >= 0) begin
            m_valid = 1'b1;
            m_tag   = tags[exp_idx];
            m_value = vals[exp_idx];
            m_src   = exp_idx;
            m_ptr   = (exp_idx + 1) % NUM_REQ;
         end else begin
            m_valid = 1'b0;
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (i == exp_idx || !req_valid[i]) wait_cnt[i] = 0;
            else if (!flush) wait_cnt[i]++;
         end
`ifdef CDB_PERF_CNT_EN
         if (exp_idx >= 0 && m_gcnt[exp_idx] < 64'hFFFF_FFFF) m_gcnt[exp_idx]++;
         if (!flush && $countones(req_valid) >= 2 && m_ccnt < 64'hFFFF_FFFF) m_ccnt++;
`endif
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   logic [NUM_REQ-1:0] rot [5];
   logic [NUM_REQ-1:0] g;
   logic [NUM_REQ-1:0] nv;
   bit                 prev_flush;
   int                 density;

   initial begin
      reset = 1'b1; flush = 1'b0; req_valid = '0;
      for (int i = 0; i < NUM_REQ; i++) begin tags[i] = '0; vals[i] = '0; end
      rot[0] = 4'b0001; rot[1] = 4'b0010; rot[2] = 4'b0100; rot[3] = 4'b1000; rot[4] = 4'b0001;

      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("rst_cdb_valid", 64'(cdb_valid), 64'd0);
      check("rst_cdb_tag",   64'(cdb_tag),   64'd0);
      check("rst_cdb_value", 64'(cdb_value), 64'd0);
      check("rst_cdb_src",   64'(cdb_src),   64'd0);
      check("rst_rr_ptr",    64'(dut.rr_ptr), 64'd0);

      // single request from LB
      tick(); tags[2] = 5'h07; vals[2] = 32'hDEAD_BEEF; req_valid = 4'b0100;
      @(negedge clock);
      check("single_written", 64'(req_written), 64'b0100);
      tick(); req_valid = '0;
      @(negedge clock);
      check("single_cdb_valid", 64'(cdb_valid), 64'd1);
      check("single_cdb_tag",   64'(cdb_tag),   64'h07);
      check("single_cdb_value", 64'(cdb_value), 64'hDEAD_BEEF);
      check("single_cdb_src",   64'(cdb_src),   64'd2);
      check("single_rr_ptr",    64'(dut.rr_ptr), 64'd3);

      // wrap: rr_ptr = 3 with requesters 0 and 1 valid
      tick(); tags[0] = 5'h01; vals[0] = 32'h1111_0000; tags[1] = 5'h02; vals[1] = 32'h2222_0000;
      req_valid = 4'b0011;
      @(negedge clock);
      check("wrap_written0", 64'(req_written), 64'b0001);
      tick(); tags[0] = 5'h03; vals[0] = 32'h3333_0000;
      @(negedge clock);
      check("wrap_rr_ptr",    64'(dut.rr_ptr), 64'd1);
      check("wrap_written1",  64'(req_written), 64'b0010);
      check("wrap_cdb_tag",   64'(cdb_tag), 64'h01);

      // flush at rr_ptr = 2 with all valid; prior broadcast completes
      tick(); req_valid = 4'b1111; flush = 1'b1;
      @(negedge clock);
      check("flush_written",  64'(req_written), 64'd0);
      check("flush_prev_bc",  64'(cdb_valid), 64'd1);
      check("flush_prev_src", 64'(cdb_src), 64'd1);
      tick(); req_valid = '0; flush = 1'b0;
      @(negedge clock);
      check("flush_cdb_valid", 64'(cdb_valid), 64'd0);
      check("flush_rr_ptr",    64'(dut.rr_ptr), 64'd2);

      // broadcast tag 9, then an idle cycle keeps the tag
      tick(); tags[2] = 5'h09; vals[2] = 32'h0000_0099; req_valid = 4'b0100;
      @(negedge clock);
      check("t9_written", 64'(req_written), 64'b0100);
      tick(); req_valid = '0;
      @(negedge clock);
      check("t9_cdb_valid", 64'(cdb_valid), 64'd1);
      tick();
      @(negedge clock);
      check("idle_cdb_valid", 64'(cdb_valid), 64'd0);
      check("idle_cdb_tag",   64'(cdb_tag),   64'h09);

      // reset mid-stream with all requesters valid
      tick(); reset = 1'b1; req_valid = 4'b1111;
      @(negedge clock);
      check("rst_mid_written", 64'(req_written), 64'd0);
      tick(); reset = 1'b0;
      @(negedge clock);
      check("rst_mid_cdb_valid", 64'(cdb_valid), 64'd0);
      check("rst_mid_cdb_tag",   64'(cdb_tag),   64'd0);
      check("rst_mid_cdb_value", 64'(cdb_value), 64'd0);
      check("rst_mid_cdb_src",   64'(cdb_src),   64'd0);
      check("rotate_0", 64'(req_written), 64'(rot[0]));
      for (int r = 1; r < 5; r++) begin
         tick();
         @(negedge clock);
         check("rotate_n", 64'(req_written), 64'(rot[r]));
      end
      tick(); req_valid = '0;

      // randomized traffic obeying the hold-until-granted protocol
      prev_flush = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clock);
         g = req_written;
         tick();
         density = ((c / 500) % 2 == 1) ? 90 : 35;
         reset = ($urandom_range(0, 199) == 0);
         flush = !reset && ($urandom_range(0, 19) == 0);
         for (int i = 0; i < NUM_REQ; i++) begin
            if (prev_flush) begin
               nv[i] = 1'b0;
            end else if (req_valid[i] && !g[i]) begin
               nv[i] = 1'b1;
            end else if ($urandom_range(0, 99) < density) begin
               nv[i] = 1'b1;
               tags[i] = TAG_W'($urandom);
               vals[i] = $urandom;
            end else begin
               nv[i] = 1'b0;
            end
         end
         req_valid  = nv;
         prev_flush = flush;
      end
      tick(); reset = 1'b0; flush = 1'b0; req_valid = '0;

`ifdef CDB_PERF_CNT_EN
      tick(); reset = 1'b1;
      tick(); reset = 1'b0; req_valid = 4'b0011;
      tick();
      tick();
      tick(); req_valid = '0;
      @(negedge clock);
      check("perf_g0", 64'(perf_grant_cnt[0]), 64'd2);
      check("perf_g1", 64'(perf_grant_cnt[1]), 64'd1);
      check("perf_g2", 64'(perf_grant_cnt[2]), 64'd0);
      check("perf_g3", 64'(perf_grant_cnt[3]), 64'd0);
      check("perf_conflict", 64'(perf_conflict_cnt), 64'd3);
`endif

      tick();
      @(negedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
